// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit positions and transmitter FSM states.
package wb_uart_pkg;

   typedef enum logic [1:0] {
      ADR_DATA   = 2'd0,
      ADR_STATUS = 2'd1,
      ADR_DIV    = 2'd2,
      ADR_IER    = 2'd3
   } adr_e;

   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic slave signal bundle for the UART transmitter.
interface wb_uart_tx_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [1:0]  wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_uart_tx_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; empty/full come from the reset pointers, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone classic UART transmitter (8N1) with TX FIFO and readable status.
// Optional interrupt output and IER register at address 3: WB_UART_TX_IRQ_EN.
module wb_uart_tx
   import wb_uart_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [15:0] DIV_RESET = 16'd433
) (
   input  logic         clk,
   input  logic         reset,
   wb_uart_tx_if.slave  bus,
`ifdef WB_UART_TX_IRQ_EN
   output logic         irq,
`endif
   output logic         tx
);
   adr_e        adr;
   logic        accept, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_dout;
   logic [15:0] status;

   logic        ack_q, ack_d, ovf_q, ovf_d, tx_q, tx_d;
   logic [15:0] dat_q, dat_d, div_q, div_d, baud_q, baud_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   tx_state_e   state_q, state_d;
`ifdef WB_UART_TX_IRQ_EN
   logic        ier_q, ier_d, irq_q, irq_d;
`endif

   // The edge that raises ack is the single point where a request takes effect.
   assign adr       = adr_e'(bus.wb_adr_i);
   assign accept    = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
   assign fifo_push = accept & bus.wb_we_i & (adr == ADR_DATA);
   assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (bus.wb_dat_i[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      status           = '0;
      status[ST_EMPTY] = fifo_empty;
      status[ST_FULL]  = fifo_full;
      status[ST_BUSY]  = (state_q != IDLE);
      status[ST_OVF]   = ovf_q;
   end

   always_comb begin
      ack_d = accept;
      dat_d = '0;
      div_d = div_q;
      ovf_d = ovf_q;
`ifdef WB_UART_TX_IRQ_EN
      ier_d = ier_q;
      irq_d = ier_q & fifo_empty & (state_q == IDLE);
`endif
      if (accept && !bus.wb_we_i) begin
         case (adr)
            ADR_STATUS: begin
               dat_d = status;
               ovf_d = 1'b0;
            end
            ADR_DIV: dat_d = div_q;
`ifdef WB_UART_TX_IRQ_EN
            ADR_IER: dat_d = {15'd0, ier_q};
`endif
            default: dat_d = '0;
         endcase
      end
      if (accept && bus.wb_we_i) begin
         case (adr)
            ADR_DATA: if (fifo_full && !fifo_pop) ovf_d = 1'b1;
            ADR_DIV:  div_d = bus.wb_dat_i;
`ifdef WB_UART_TX_IRQ_EN
            ADR_IER:  ier_d = bus.wb_dat_i[0];
`endif
            default: ;
         endcase
      end
   end

   // A new divisor is only picked up on reload, so the bit in flight keeps its length.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: if (!fifo_empty) begin
            shift_d = fifo_dout;
            baud_d  = div_q;
            state_d = START;
         end
         START: if (baud_q == '0) begin
            baud_d  = div_q;
            bit_d   = '0;
            state_d = DATA;
         end else baud_d = baud_q - 16'd1;
         DATA: if (baud_q == '0) begin
            baud_d  = div_q;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
         end else baud_d = baud_q - 16'd1;
         STOP: if (baud_q == '0) state_d = IDLE;
               else baud_d = baud_q - 16'd1;
         default: state_d = IDLE;
      endcase
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_q   <= 1'b0;
         dat_q   <= '0;
         div_q   <= DIV_RESET;
         ovf_q   <= 1'b0;
         tx_q    <= 1'b1;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         state_q <= IDLE;
`ifdef WB_UART_TX_IRQ_EN
         ier_q   <= 1'b0;
         irq_q   <= 1'b0;
`endif
      end else begin
         ack_q   <= ack_d;
         dat_q   <= dat_d;
         div_q   <= div_d;
         ovf_q   <= ovf_d;
         tx_q    <= tx_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         state_q <= state_d;
`ifdef WB_UART_TX_IRQ_EN
         ier_q   <= ier_d;
         irq_q   <= irq_d;
`endif
      end
   end

   assign bus.wb_ack_o = ack_q;
   assign bus.wb_dat_o = dat_q;
   assign tx           = tx_q;
`ifdef WB_UART_TX_IRQ_EN
   assign irq          = irq_q;
`endif
endmodule
